// File: rtl/video_pattern_gen.sv
// Video timing generator with selectable test patterns (marker, bars, checkerboard, gradient, flat).
// Sync/DE/data are registered one cycle after the timing position; pattern settings change only at frame start.
module video_pattern_gen #(
  parameter int unsigned H_ACTIVE      = 1280,
  parameter int unsigned H_FRONT_PORCH = 110,
  parameter int unsigned H_SYNC        = 40,
  parameter int unsigned H_BACK_PORCH  = 220,
  parameter int unsigned V_ACTIVE      = 720,
  parameter int unsigned V_FRONT_PORCH = 5,
  parameter int unsigned V_SYNC        = 5,
  parameter int unsigned V_BACK_PORCH  = 20,
  parameter bit          HS_POL        = 1'b1,
  parameter bit          VS_POL        = 1'b1,
  parameter int unsigned DATA_W        = 24,
  parameter int unsigned RADIUS        = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic [3:0]        marker_sel,
  output logic              de,
  output logic              hs,
  output logic              vs,
  output logic [DATA_W-1:0] data,
  output logic              sof,
  output logic [15:0]       frame_cnt
);

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  localparam int unsigned CH_W  = DATA_W / 3;
  localparam int unsigned H_MAX = max4(H_ACTIVE, H_FRONT_PORCH, H_SYNC, H_BACK_PORCH);
  localparam int unsigned V_MAX = max4(V_ACTIVE, V_FRONT_PORCH, V_SYNC, V_BACK_PORCH);
  localparam int unsigned HW    = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam int unsigned VW    = (V_MAX > 1) ? $clog2(V_MAX) : 1;
  localparam int unsigned PW    = HW + CH_W;
  localparam logic [CH_W-1:0] CH_ONES = '1;

  typedef enum logic [1:0] {ST_BP, ST_ACT, ST_FP, ST_SYNC} tstate_e;

  function automatic tstate_e next_st(input tstate_e s);
    case (s)
      ST_BP:   return ST_ACT;
      ST_ACT:  return ST_FP;
      ST_FP:   return ST_SYNC;
      default: return ST_BP;
    endcase
  endfunction

  // Marker window along one axis: sel picks left/top, centre or right/bottom edge.
  function automatic logic in_rng(input int unsigned p, input int unsigned sel, input int unsigned n);
    case (sel)
      0:       return p <= 2 * RADIUS;
      1:       return (p + RADIUS >= n / 2) && (p <= n / 2 + RADIUS);
      2:       return p + 2 * RADIUS + 1 >= n;
      default: return 1'b0;
    endcase
  endfunction

  tstate_e         h_st, v_st;
  logic [HW-1:0]   h_cnt, h_last;
  logic [VW-1:0]   v_cnt, v_last;
  logic [2:0]      mode_s1, mode_s2, mode_f;
  logic [3:0]      marker_s1, marker_s2, marker_f;
  logic            h_end_c, v_end_c, line_end_c, frame_start_c, de_c;
  logic [DATA_W-1:0] pix_c;
  int unsigned     px, py;
  logic [2:0]      rgb;
  logic [CH_W-1:0] grad;

  always_comb begin
    h_last = HW'(H_BACK_PORCH - 1);
    case (h_st)
      ST_ACT:  h_last = HW'(H_ACTIVE - 1);
      ST_FP:   h_last = HW'(H_FRONT_PORCH - 1);
      ST_SYNC: h_last = HW'(H_SYNC - 1);
      default: ;
    endcase
    v_last = VW'(V_BACK_PORCH - 1);
    case (v_st)
      ST_ACT:  v_last = VW'(V_ACTIVE - 1);
      ST_FP:   v_last = VW'(V_FRONT_PORCH - 1);
      ST_SYNC: v_last = VW'(V_SYNC - 1);
      default: ;
    endcase
    h_end_c       = (h_cnt == h_last);
    v_end_c       = (v_cnt == v_last);
    line_end_c    = h_end_c && (h_st == ST_SYNC);
    frame_start_c = (h_st == ST_BP) && (v_st == ST_BP) && (h_cnt == '0) && (v_cnt == '0);
    de_c          = (h_st == ST_ACT) && (v_st == ST_ACT);
  end

  // Pattern for the current position, using the frame-stable settings.
  always_comb begin
    px    = 32'(h_cnt);
    py    = 32'(v_cnt);
    rgb   = 3'b000;
    grad  = CH_W'((PW'(h_cnt) * PW'(CH_ONES)) / PW'(H_ACTIVE - 1));
    pix_c = '0;
    case (3'(px * 8 / H_ACTIVE))
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    case (mode_f)
      3'd0: if (marker_f <= 4'd8 && in_rng(px, 32'(marker_f) % 3, H_ACTIVE) &&
                in_rng(py, 32'(marker_f) / 3, V_ACTIVE)) pix_c = '1;
      3'd1: pix_c = {{CH_W{rgb[2]}}, {CH_W{rgb[1]}}, {CH_W{rgb[0]}}};
      3'd2: if (px[5] ^ py[5]) pix_c = '1;
      3'd3: pix_c = {grad, grad, grad};
      3'd4: pix_c = '1;
      default: pix_c = '0;
    endcase
  end

  // Control inputs arrive asynchronously; synchronise unconditionally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_s1   <= '0;
      mode_s2   <= '0;
      marker_s1 <= '0;
      marker_s2 <= '0;
    end else begin
      mode_s1   <= mode;
      mode_s2   <= mode_s1;
      marker_s1 <= marker_sel;
      marker_s2 <= marker_s1;
    end
  end

  // Timing state machines, frame-stable settings and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_st      <= ST_BP;
      v_st      <= ST_BP;
      h_cnt     <= '0;
      v_cnt     <= '0;
      mode_f    <= '0;
      marker_f  <= '0;
      de        <= 1'b0;
      hs        <= ~HS_POL;
      vs        <= ~VS_POL;
      data      <= '0;
      sof       <= 1'b0;
      frame_cnt <= '0;
    end else if (en) begin
      if (h_end_c) begin
        h_cnt <= '0;
        h_st  <= next_st(h_st);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
      if (line_end_c) begin
        if (v_end_c) begin
          v_cnt <= '0;
          v_st  <= next_st(v_st);
        end else begin
          v_cnt <= v_cnt + VW'(1);
        end
      end
      de   <= de_c;
      hs   <= (h_st == ST_SYNC) ? HS_POL : ~HS_POL;
      vs   <= (v_st == ST_SYNC) ? VS_POL : ~VS_POL;
      data <= de_c ? pix_c : '0;
      sof  <= frame_start_c;
      if (frame_start_c) begin
        frame_cnt <= frame_cnt + 16'd1;
        mode_f    <= mode_s2;
        marker_f  <= marker_s2;
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Randomised check of video_pattern_gen against a position-arithmetic reference model.
module tb_video_pattern_gen;

  localparam int HA = 72, HF = 3, HSY = 4, HB = 5;
  localparam int VA = 36, VF = 2, VSY = 3, VB = 2;
  localparam bit HP = 1'b0, VP = 1'b1;
  localparam int RAD = 2;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FR = HT * VT;
  localparam logic [43:0] RST_V = {1'b0, ~HP, ~VP, 1'b0, 16'h0, 24'h0};

  logic clk = 1'b0;
  logic resetn, en;
  logic [2:0] mode;
  logic [3:0] marker_sel;
  logic de, hs, vs, sof;
  logic [23:0] data;
  logic [15:0] frame_cnt;
  logic [43:0] dutv;

  always #5 clk = ~clk;
  assign dutv = {de, hs, vs, sof, frame_cnt, data};

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FRONT_PORCH(HF), .H_SYNC(HSY), .H_BACK_PORCH(HB),
    .V_ACTIVE(VA), .V_FRONT_PORCH(VF), .V_SYNC(VSY), .V_BACK_PORCH(VB),
    .HS_POL(HP), .VS_POL(VP), .DATA_W(24), .RADIUS(RAD)
  ) dut (
    .clk(clk), .resetn(resetn), .en(en), .mode(mode), .marker_sel(marker_sel),
    .de(de), .hs(hs), .vs(vs), .data(data), .sof(sof), .frame_cnt(frame_cnt)
  );

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state: enabled edges since reset and the settings pipeline.
  int k;
  int fm, fk, md1, md2, kd1, kd2;
  logic [43:0] exp_v;
  int ones;

  function automatic bit rng(input int p, input int sel, input int n);
    case (sel)
      0:       return p <= 2 * RAD;
      1:       return p >= n / 2 - RAD && p <= n / 2 + RAD;
      2:       return p >= n - 2 * RAD - 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [23:0] ref_pix(input int m, input int mk, input int x, input int y);
    logic [2:0] c;
    int g;
    case (m)
      0: return (mk <= 8 && rng(x, mk % 3, HA) && rng(y, mk / 3, VA)) ? 24'hFFFFFF : 24'h0;
      1: begin
        case (x * 8 / HA)
          0: c = 3'b111; 1: c = 3'b110; 2: c = 3'b011; 3: c = 3'b010;
          4: c = 3'b101; 5: c = 3'b100; 6: c = 3'b001; default: c = 3'b000;
        endcase
        return {c[2] ? 8'hFF : 8'h00, c[1] ? 8'hFF : 8'h00, c[0] ? 8'hFF : 8'h00};
      end
      2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h0;
      3: begin
        g = x * 255 / (HA - 1);
        return {8'(g), 8'(g), 8'(g)};
      end
      4: return 24'hFFFFFF;
      default: return 24'h0;
    endcase
  endfunction

  // 0 back porch, 1 active, 2 front porch, 3 sync
  function automatic int region(input int c, input int bp, input int act, input int fp, output int off);
    off = c - bp;
    if (c < bp) return 0;
    if (c < bp + act) return 1;
    if (c < bp + act + fp) return 2;
    return 3;
  endfunction

  function automatic logic [43:0] ref_out(input int p, input int fcnt, input int m, input int mk);
    int x, y, hr, vr;
    logic d, h, v;
    hr = region(p % HT, HB, HA, HF, x);
    vr = region(p / HT, VB, VA, VF, y);
    d = (hr == 1) && (vr == 1);
    h = (hr == 3) ? HP : ~HP;
    v = (vr == 3) ? VP : ~VP;
    return {d, h, v, p == 0, 16'(fcnt), d ? ref_pix(m, mk, x, y) : 24'h0};
  endfunction

  task automatic model_edge();
    int p;
    if (!resetn) begin
      k = 0; fm = 0; fk = 0; md1 = 0; md2 = 0; kd1 = 0; kd2 = 0;
      exp_v = RST_V;
      return;
    end
    if (en) begin
      p = k % FR;
      if (p == 0) begin
        fm = md2;
        fk = kd2;
      end
      exp_v = ref_out(p, (k / FR + 1) % 65536, fm, fk);
      k++;
    end
    md2 = md1; md1 = int'(mode);
    kd2 = kd1; kd1 = int'(marker_sel);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("outputs", 64'(dutv), 64'(exp_v));
    if (data != 24'h0) ones++;
  endtask

  // style 0: en held high, 1: en toggled, 2: en random; chg>0 randomises settings ~1/chg cycles
  task automatic run(input int n, input int style, input int chg);
    for (int i = 0; i < n && bad <= 40; i++) begin
      step();
      case (style)
        0: en = 1'b1;
        1: en = ~en;
        default: en = 1'($urandom_range(0, 1));
      endcase
      if (chg > 0 && $urandom_range(0, chg - 1) == 0) begin
        mode = 3'($urandom_range(0, 7));
        marker_sel = 4'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin
    int waited;
    resetn = 1'b0; en = 1'b1; mode = 3'd0; marker_sel = 4'd4;
    k = 0; fm = 0; fk = 0; md1 = 0; md2 = 0; kd1 = 0; kd2 = 0;
    exp_v = RST_V;
    #12;
    check("reset_values", 64'(dutv), 64'(RST_V));
    @(negedge clk);
    resetn = 1'b1;

    // First frame uses marker 0 (settings still clearing), second marker 4: 25 lit pixels each.
    ones = 0;
    run(2 * FR, 0, 0);
    check("marker_pixels", 64'(ones), 64'd50);

    for (int m = 1; m < 8; m++) begin
      mode = 3'(m);
      run(FR, 0, 0);
    end

    // Mid-frame switch from bars to checkerboard.
    mode = 3'd1;
    run(FR + FR / 2, 0, 0);
    mode = 3'd2;
    run(FR, 0, 0);

    mode = 3'd3;
    en = 1'b0;
    run(2 * FR, 1, 0);

    run(4 * FR, 2, 400);

    // Reset in the middle of an active line.
    en = 1'b1; mode = 3'd4;
    waited = 0;
    while (exp_v[43] !== 1'b1 && waited < 2 * FR) begin
      step();
      waited++;
    end
    check("reach_active", 64'(exp_v[43]), 64'd1);
    run(3, 0, 0);
    @(posedge clk);
    model_edge();
    #2 resetn = 1'b0;
    #1 check("async_reset", 64'(dutv), 64'(RST_V));
    step();
    step();
    resetn = 1'b1;
    step();
    check("sof_after_reset", 64'(sof), 64'd1);
    check("frame_cnt_after_reset", 64'(frame_cnt), 64'd1);
    run(FR + 10, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameters H_FRONT_PORCH 110, H_SYNC 40, H_BACK_PORCH 220, each giving horizontal interval lengths in pixels.
REQ-003 SHALL have parameter V_ACTIVE 720, active lines per frame, plus V_FRONT_PORCH 5, V_SYNC 5 and V_BACK_PORCH 20, each giving vertical interval lengths in lines.
REQ-004 SHALL have parameters HS_POL 1 and VS_POL 1: the asserted sync level (1 = active-high).
REQ-005 SHALL have parameter DATA_W, default 24, the pixel width; it is a multiple of 3 and CH_W = DATA_W/3 per channel, with R in the MSBs and B in the LSBs.
REQ-006 SHALL have parameter RADIUS, default 2, the marker half-size in pixels and lines.
REQ-007 clk  input  1  pixel clock.
REQ-008 resetn  input  1  reset, asynchronous, active-low.
REQ-009 en  input  1  advance enable; when low, timing and outputs freeze.
REQ-010 mode  input  3  pattern select, asynchronous to clk.
REQ-011 marker_sel  input  4  marker position 0-8, asynchronous to clk.
REQ-012 de  output  1  data enable.
REQ-013 hs  output  1  horizontal sync, at HS_POL level when asserted.
REQ-014 vs  output  1  vertical sync, at VS_POL level when asserted.
REQ-015 data  output  DATA_W  pixel value.
REQ-016 sof  output  1  single-cycle start-of-frame pulse.
REQ-017 frame_cnt  output  16  count of frames started since reset.

Function
REQ-018 SHALL sequence the horizontal states BACK_PORCH -> ACTIVE -> FRONT_PORCH -> SYNC -> BACK_PORCH, with each state lasting its parameter length in cycles.
REQ-019 SHALL use the same state order for vertical, advancing one line on each exit of the horizontal SYNC state.
REQ-020 SHALL size each counter to $clog2 of the largest interval on its axis, and each counter SHALL wrap to 0 on a state change.
REQ-021 SHALL advance counters and update registered outputs only in cycles with en=1; with en=0 every register holds, including sof.
REQ-022 SHALL register all outputs with 1-cycle latency from the counter position: de = both axes ACTIVE; hs = horizontal SYNC; vs = vertical SYNC.
REQ-023 SHALL pass mode and marker_sel through a 2-flop synchroniser each, on every clk regardless of en.
REQ-024 SHALL latch the synchronised mode/marker_sel into frame-stable copies only at frame start (v and h both BACK_PORCH, both counts 0, en=1), so no pattern changes mid-frame.
REQ-025 SHALL pulse sof for one enabled cycle aligned with the frame-start position, and SHALL increment frame_cnt in that same cycle, wrapping 0xFFFF -> 0.
REQ-026 SHALL drive data to 0 whenever de=0.
REQ-027 mode 0 (marker): data = all ones where both the h and v ranges hit, else 0.
 - h: marker_sel%3 = 0 -> x <= 2*RADIUS; 1 -> H_ACTIVE/2-RADIUS <= x <= H_ACTIVE/2+RADIUS; 2 -> x >= H_ACTIVE-2*RADIUS-1.
 - v: marker_sel/3 with the same rule on y and V_ACTIVE.
 - marker_sel > 8 -> black.
REQ-028 mode 1 (colour bars): bar index = x*8/H_ACTIVE, in integer arithmetic.
 - Bar order: white, yellow, cyan, green, magenta, red, blue, black.
 - Each channel is all ones or 0.
REQ-029 mode 2 (checkerboard): data = all ones when x[5]^y[5]=1, else 0.
REQ-030 mode 3 (gradient): every channel = (x*(2^CH_W-1))/(H_ACTIVE-1), truncated to CH_W.
 - x=0 -> 0; x=H_ACTIVE-1 -> all ones.
REQ-031 mode 4 SHALL output all ones; modes 5-7 SHALL output all zeros.
REQ-032 Here x and y are the active-region h and v counts.

Reset
REQ-033 SHALL, on resetn low and asynchronously, clear both states to BACK_PORCH and all counts to 0; reset mid-frame restarts from frame start.
REQ-034 SHALL, during reset, drive de=0, hs=!HS_POL, vs=!VS_POL, data=0, sof=0 and frame_cnt=0.
REQ-035 SHALL clear the synchronisers and the frame-stable copies to 0, i.e. mode 0 with marker 0.

Verification
REQ-036 Small frame (H 16/2/2/2, V 8/1/1/1), en=1, mode 4 -> period 22x11 cycles; de high 16 cycles/line on 8 lines; hs width 2; vs width 1 line.
REQ-037 HS_POL=0, VS_POL=0 -> sync idle-high and pulsed low; reset values hs=1, vs=1.
REQ-038 Default timing, mode 0, marker_sel 4 -> ones only at x 638..642, y 358..362 (25 pixels/frame).
REQ-039 Change mode 1->2 mid-frame -> current frame stays colour bars; the next frame after sof is checkerboard.
REQ-040 en toggled 1/0 each cycle -> identical output sequence to en=1, stretched 2x; sof count per frame = 1.
REQ-041 Reset asserted mid-active-line -> outputs go to reset values immediately; after release, first sof is 1 cycle later and frame_cnt counts from 1.
